// File: rtl/eater_out_display.sv
// Captures bytes from the OUT register, converts them to decimal with a sequential
// double-dabble and scans a 4-digit 7-segment display. Define OUT_DISP_HEX_EN for hex mode.
module eater_out_display #(
  parameter int SCAN_DIV = 1024
) (
  input  logic       fastClk,
  input  logic       rst,
  input  logic       out_load,
  input  logic [7:0] out_data,
  input  logic       signed_mode,
`ifdef OUT_DISP_HEX_EN
  input  logic       hex_mode,
`endif
  output logic [6:0] seg,
  output logic [3:0] dig_sel,
  output logic       busy,
  output logic       bcd_valid
);

  localparam int CW = $clog2(SCAN_DIV);

  typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_t;

  state_t        state;
  logic [2:0]    iter;
  logic [7:0]    bin;
  logic [11:0]   bcd;
  logic          conv_neg;
  logic          conv_hex;

  logic          pend_full;
  logic [7:0]    pend_data;
  logic          pend_signed;
  logic          pend_hex;

  logic [3:0]    disp_h;
  logic [3:0]    disp_t;
  logic [3:0]    disp_o;
  logic          disp_neg;
  logic          disp_hex;

  logic [CW-1:0] scan_cnt;
  logic [1:0]    dig_idx;

  logic          load_hex;
`ifdef OUT_DISP_HEX_EN
  assign load_hex = hex_mode;
`else
  assign load_hex = 1'b0;
`endif

  // Source of the next conversion: a full pending slot in COMMIT beats a fresh load.
  logic       use_pend;
  logic       start;
  logic       pend_wr;
  logic [7:0] src_data;
  logic [7:0] src_mag;
  logic       src_signed;
  logic       src_hex;
  logic       src_neg;

  always_comb begin
    use_pend   = (state == COMMIT) && pend_full;
    src_data   = use_pend ? pend_data   : out_data;
    src_signed = use_pend ? pend_signed : signed_mode;
    src_hex    = use_pend ? pend_hex    : load_hex;
    src_neg    = !src_hex && src_signed && src_data[7];
    src_mag    = src_neg ? (~src_data + 8'd1) : src_data;
    start      = ((state == IDLE) || (state == COMMIT)) && (use_pend || out_load);
    pend_wr    = out_load && ((state == CONV) || use_pend);
  end

  function automatic logic [11:0] dd_adjust(input logic [11:0] b);
    logic [11:0] r;
    for (int i = 0; i < 3; i++)
      r[i*4 +: 4] = (b[i*4 +: 4] >= 4'd5) ? b[i*4 +: 4] + 4'd3 : b[i*4 +: 4];
    return r;
  endfunction

  logic [11:0] bcd_adj;
  assign bcd_adj = dd_adjust(bcd);

  always_ff @(posedge fastClk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      busy        <= 1'b0;
      bcd_valid   <= 1'b0;
      iter        <= 3'd0;
      bin         <= 8'h00;
      bcd         <= 12'h000;
      conv_neg    <= 1'b0;
      conv_hex    <= 1'b0;
      pend_full   <= 1'b0;
      pend_data   <= 8'h00;
      pend_signed <= 1'b0;
      pend_hex    <= 1'b0;
      disp_h      <= 4'd0;
      disp_t      <= 4'd0;
      disp_o      <= 4'd0;
      disp_neg    <= 1'b0;
      disp_hex    <= 1'b0;
    end else begin
      bcd_valid <= 1'b0;
      case (state)
        CONV: begin
          bcd  <= {bcd_adj[10:0], bin[7]};
          bin  <= {bin[6:0], 1'b0};
          iter <= iter + 3'd1;
          if (iter == 3'd7) state <= COMMIT;
        end
        COMMIT: begin
          disp_h    <= bcd[11:8];
          disp_t    <= bcd[7:4];
          disp_o    <= bcd[3:0];
          disp_neg  <= conv_neg;
          disp_hex  <= conv_hex;
          bcd_valid <= 1'b1;
          state     <= IDLE;
          busy      <= 1'b0;
        end
        default: ;
      endcase
      // A start overrides the COMMIT -> IDLE default above.
      if (start) begin
        state    <= src_hex ? COMMIT : CONV;
        busy     <= 1'b1;
        iter     <= 3'd0;
        bin      <= src_mag;
        bcd      <= src_hex ? {4'h0, src_data} : 12'h000;
        conv_neg <= src_neg;
        conv_hex <= src_hex;
      end
      if (use_pend) pend_full <= 1'b0;
      if (pend_wr) begin
        pend_full   <= 1'b1;
        pend_data   <= out_data;
        pend_signed <= signed_mode;
        pend_hex    <= load_hex;
      end
    end
  end

  always_ff @(posedge fastClk or posedge rst) begin
    if (rst) begin
      scan_cnt <= '0;
      dig_idx  <= 2'd0;
    end else if (scan_cnt == CW'(SCAN_DIV - 1)) begin
      scan_cnt <= '0;
      dig_idx  <= dig_idx + 2'd1;
    end else begin
      scan_cnt <= scan_cnt + CW'(1);
    end
  end

  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'h0: return 7'h3F;
      4'h1: return 7'h06;
      4'h2: return 7'h5B;
      4'h3: return 7'h4F;
      4'h4: return 7'h66;
      4'h5: return 7'h6D;
      4'h6: return 7'h7D;
      4'h7: return 7'h07;
      4'h8: return 7'h7F;
      4'h9: return 7'h6F;
      4'hA: return 7'h77;
      4'hB: return 7'h7C;
      4'hC: return 7'h39;
      4'hD: return 7'h5E;
      4'hE: return 7'h79;
      default: return 7'h71;
    endcase
  endfunction

  // Display only ever reads committed registers, never the conversion datapath.
  always_comb begin
    dig_sel = 4'b0001 << dig_idx;
    seg     = 7'h00;
    case (dig_idx)
      2'd0: seg = seg7(disp_o);
      2'd1: if (disp_hex || disp_h != 4'd0 || disp_t != 4'd0) seg = seg7(disp_t);
      2'd2: if (!disp_hex && disp_h != 4'd0) seg = seg7(disp_h);
      default: if (!disp_hex && disp_neg) seg = 7'h40;
    endcase
  end

endmodule

// File: tb/tb_eater_out_display.sv
// Bench for eater_out_display: random and directed OUT loads against a
// transaction-level model; expected displays flow through exp_q to a negedge monitor.
module tb_eater_out_display;

  localparam int SCAN_DIV = 4;
  localparam logic [27:0] RESET_DISP = {7'h00, 7'h00, 7'h00, 7'h3F};

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       out_load = 1'b0;
  logic [7:0] out_data = 8'h00;
  logic       signed_mode = 1'b0;
  logic       hex_mode = 1'b0;
  logic       hex_eff;
  logic [6:0] seg;
  logic [3:0] dig_sel;
  logic       busy;
  logic       bcd_valid;

  int total = 0;
  int bad = 0;
  int vcount = 0;

  logic [27:0] exp_q[$];
  logic [27:0] cur_disp;

`ifdef OUT_DISP_HEX_EN
  assign hex_eff = hex_mode;
`else
  assign hex_eff = 1'b0;
`endif

  always #5 clk = ~clk;

  eater_out_display #(.SCAN_DIV(SCAN_DIV)) dut (
    .fastClk     (clk),
    .rst         (rst),
    .out_load    (out_load),
    .out_data    (out_data),
    .signed_mode (signed_mode),
`ifdef OUT_DISP_HEX_EN
    .hex_mode    (hex_mode),
`endif
    .seg         (seg),
    .dig_sel     (dig_sel),
    .busy        (busy),
    .bcd_valid   (bcd_valid)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] seg_of(input logic [3:0] n);
    logic [6:0] tab [16];
    tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
            7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    return tab[n];
  endfunction

  // Expected digit patterns {dig3,dig2,dig1,dig0} straight from the display rules.
  function automatic logic [27:0] disp_of(input logic [7:0] d, input logic s, input logic h);
    int v, hu, te, on;
    logic neg;
    if (h) return {7'h00, 7'h00, seg_of(d[7:4]), seg_of(d[3:0])};
    neg = s && d[7];
    v   = neg ? 256 - int'(d) : int'(d);
    hu  = v / 100;
    te  = (v / 10) % 10;
    on  = v % 10;
    return {neg ? 7'h40 : 7'h00,
            (hu == 0) ? 7'h00 : seg_of(4'(hu)),
            (hu == 0 && te == 0) ? 7'h00 : seg_of(4'(te)),
            seg_of(4'(on))};
  endfunction

  // Transaction model: one conversion in flight, one latest-wins pending slot.
  int          m_edges = 0;
  int          m_end = 0;
  bit          m_act = 1'b0;
  bit          m_valid = 1'b0;
  bit          m_pend = 1'b0;
  logic [27:0] m_cur;
  logic [27:0] m_pend_disp;
  int          m_pend_lat;
  logic [27:0] ld_disp;
  int          ld_lat;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_edges = 0;
      m_act   = 1'b0;
      m_pend  = 1'b0;
      m_valid = 1'b0;
      exp_q.delete();
    end else begin
      m_edges++;
      m_valid = 1'b0;
      ld_disp = disp_of(out_data, signed_mode, hex_eff);
      ld_lat  = hex_eff ? 1 : 9;
      if (m_act && m_edges == m_end) begin
        exp_q.push_back(m_cur);
        m_valid = 1'b1;
        if (m_pend) begin
          m_cur  = m_pend_disp;
          m_end  = m_edges + m_pend_lat;
          m_pend = out_load;
          m_pend_disp = ld_disp;
          m_pend_lat  = ld_lat;
        end else if (out_load) begin
          m_cur = ld_disp;
          m_end = m_edges + ld_lat;
        end else begin
          m_act = 1'b0;
        end
      end else if (m_act) begin
        if (out_load) begin
          m_pend      = 1'b1;
          m_pend_disp = ld_disp;
          m_pend_lat  = ld_lat;
        end
      end else if (out_load) begin
        m_act = 1'b1;
        m_cur = ld_disp;
        m_end = m_edges + ld_lat;
      end
    end
  end

  // Monitor: pops on every bcd_valid and checks the scanned digit each cycle.
  always @(negedge clk) begin
    int idx;
    if (rst) cur_disp = RESET_DISP;
    if (bcd_valid === 1'b1) begin
      vcount++;
      if (exp_q.size() == 0) check("bcd_valid_unexpected", 32'd1, 32'd0);
      else cur_disp = exp_q.pop_front();
    end
    check("busy", busy, m_act);
    check("bcd_valid", bcd_valid, m_valid);
    idx = (m_edges / SCAN_DIV) % 4;
    check("dig_sel", dig_sel, 4'b0001 << idx);
    check("seg", seg, cur_disp[idx*7 +: 7]);
  end

  task automatic do_load(input logic [7:0] d, input logic s, input logic h);
    @(negedge clk);
    out_load = 1'b1; out_data = d; signed_mode = s; hex_mode = h;
    @(negedge clk);
    out_load = 1'b0; out_data = 8'($urandom); signed_mode = 1'($urandom); hex_mode = 1'($urandom);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_reset();
    @(posedge clk); #2 rst = 1'b1;
    @(posedge clk); #2 rst = 1'b0;
  endtask

  task automatic check_digits(input string name, input logic [27:0] exp);
    for (int k = 0; k < 4 * SCAN_DIV; k++) begin
      @(negedge clk);
      for (int j = 0; j < 4; j++)
        if (dig_sel == (4'b0001 << j)) check(name, seg, exp[j*7 +: 7]);
    end
  endtask

  initial begin
    int v0;
    logic [7:0] d;
    #2 rst = 1'b1;
    #20 rst = 1'b0;
    check_digits("reset_digits", RESET_DISP);

    do_load(8'hFF, 1'b0, 1'b0);
    idle(12);
    check_digits("dec_255", {7'h00, 7'h5B, 7'h6D, 7'h6D});

    do_load(8'h80, 1'b1, 1'b0);
    idle(12);
    check_digits("neg_128", {7'h40, 7'h06, 7'h5B, 7'h7F});
    do_load(8'hF9, 1'b1, 1'b0);
    idle(12);
    check_digits("neg_7", {7'h40, 7'h00, 7'h00, 7'h07});

    v0 = vcount;
    do_load(8'h0A, 1'b0, 1'b0);
    idle(1);
    do_load(8'h2A, 1'b0, 1'b0);
    do_load(8'h63, 1'b0, 1'b0);
    idle(30);
    check("latest_wins_pulses", vcount - v0, 2);
    check_digits("latest_wins_99", {7'h00, 7'h00, 7'h6F, 7'h6F});

    v0 = vcount;
    do_load(8'h64, 1'b0, 1'b0);
    idle(2);
    pulse_reset();
    idle(20);
    check("reset_mid_pulses", vcount - v0, 0);
    check_digits("reset_mid_digits", RESET_DISP);

`ifdef OUT_DISP_HEX_EN
    do_load(8'hA7, 1'b1, 1'b1);
    idle(4);
    check_digits("hex_a7", {7'h00, 7'h00, 7'h77, 7'h07});
`endif

    for (int i = 0; i < 250; i++) begin
      case ($urandom_range(0, 5))
        0: d = 8'h80;
        1: d = 8'h00;
        2: d = 8'hFF;
        default: d = 8'($urandom);
      endcase
      do_load(d, 1'($urandom), 1'($urandom_range(0, 3) == 0));
      idle($urandom_range(0, 12));
      if (i == 120) pulse_reset();
    end

    idle(30);
    check("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
